// File: rtl/rand_range_sampler_if.sv
`default_nettype none
// ============================================================================
// rand_range_sampler_if : request/response bundle for rand_range_sampler
// Rev 1.0
// ============================================================================
interface rand_range_sampler_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_limit;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_tries;
    logic             rsp_biased;
    logic             rsp_err;

    modport master (
        output req_valid, req_limit, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tries, rsp_biased, rsp_err
    );

    modport slave (
        input  req_valid, req_limit, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tries, rsp_biased, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/rand_range_sampler.sv
`default_nettype none
// ============================================================================
// rand_range_sampler : uniform integer in [0, limit) by masked rejection
// sampling of an LFSR stream, with a bounded-retry fold-down fallback.
// Rev 1.0
// ============================================================================
module rand_range_sampler #(
    parameter int WIDTH     = 16,
    parameter int MAX_TRIES = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [63:0] lfsr_state,
    rand_range_sampler_if.slave bus
);

    localparam logic [3:0] c_max_tries = 4'(MAX_TRIES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       tries_q, tries_d;
    logic             biased_q, biased_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] smear;
    logic [WIDTH-1:0] candidate;
    logic [3:0]       tries_inc;

    generate
        if (WIDTH < 64) begin : g_unused_hi
            logic unused_lfsr_hi;
            assign unused_lfsr_hi = ^lfsr_state[63:WIDTH];
        end
    endgenerate

    // Smear the top set bit of (limit-1) downward to get the smallest 2^k-1 cover.
    always_comb begin
        smear = bus.req_limit - WIDTH'(1);
        for (int i = 0; i < WIDTH; i++) begin
            smear = smear | (smear >> 1);
        end
    end

    assign candidate = lfsr_state[WIDTH-1:0] & mask_q;
    assign tries_inc = tries_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        mask_d   = mask_q;
        data_d   = data_q;
        tries_d  = tries_q;
        biased_d = biased_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    limit_d  = bus.req_limit;
                    mask_d   = smear;
                    tries_d  = 4'd0;
                    data_d   = '0;
                    biased_d = 1'b0;
                    err_d    = 1'b0;
                    if (bus.req_limit == '0) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            DRAW: begin
                tries_d = tries_inc;
                if (candidate < limit_q) begin
                    data_d   = candidate;
                    biased_d = 1'b0;
                    state_d  = RESP;
                end else if (tries_inc == c_max_tries) begin
                    // candidate <= mask < 2*limit, so one subtraction lands in range.
                    data_d   = candidate - limit_q;
                    biased_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            limit_q     <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            tries_q     <= 4'd0;
            biased_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            limit_q     <= limit_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            tries_q     <= tries_d;
            biased_q    <= biased_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_data   = data_q;
    assign bus.rsp_tries  = tries_q;
    assign bus.rsp_biased = biased_q;
    assign bus.rsp_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rand_range_sampler.sv
`default_nettype none
// ============================================================================
// tb_rand_range_sampler : table-driven scoreboard bench for rand_range_sampler
// Rev 1.0
// ============================================================================
module tb_rand_range_sampler;

    logic        clk;
    logic        reset;
    logic [63:0] lfsr;
    int          cyc;
    int          t0;
    int          n_vec;
    int          n_bad;

    typedef struct {
        logic [15:0] limit;
        logic [15:0] lfsr_lo;
        logic [15:0] data;
        logic [3:0]  tries;
        logic        biased;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];

    rand_range_sampler_if #(.WIDTH(16)) bus ();

    rand_range_sampler #(
        .WIDTH     (16),
        .MAX_TRIES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lfsr_state (lfsr),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshake one request; returns at the falling edge after the accepting edge.
    task automatic issue(input vec_t v);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_limit = v.limit;
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        bus.req_valid = 1'b0;
        bus.req_limit = ~v.limit;
    endtask

    task automatic collect(input int stall);
        vec_t e;
        int   guard;
        guard = 0;
        while (!bus.rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("rsp_valid_rise", 32'(bus.rsp_valid), 32'd1);
        e = exp_q.pop_front();
        check("latency", 32'(cyc - t0 + 1), 32'(e.lat));
        for (int s = 0; s <= stall; s++) begin
            check("rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
            check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            check("rsp_tries", 32'(bus.rsp_tries), 32'(e.tries));
            check("rsp_biased", 32'(bus.rsp_biased), 32'(e.biased));
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
            if (s < stall) @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        check("req_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        logic rose;

        n_vec = 0;
        n_bad = 0;
        t0    = 0;
        reset = 1'b0;
        lfsr  = 64'h0;
        bus.req_valid = 1'b0;
        bus.req_limit = 16'h0;
        bus.rsp_ready = 1'b0;

        // limit, lfsr[15:0], data, tries, biased, err, latency (edges)
        vecs[0]  = '{16'd1,      16'h5678, 16'd0,      4'd1, 1'b0, 1'b0, 2};
        vecs[1]  = '{16'd0,      16'h1234, 16'd0,      4'd0, 1'b0, 1'b1, 1};
        vecs[2]  = '{16'd200,    16'h00FA, 16'd50,     4'd8, 1'b1, 1'b0, 9};
        vecs[3]  = '{16'd200,    16'h1205, 16'd5,      4'd1, 1'b0, 1'b0, 2};
        vecs[4]  = '{16'h8000,   16'hFFFF, 16'h7FFF,   4'd1, 1'b0, 1'b0, 2};
        vecs[5]  = '{16'hFFFF,   16'hFFFF, 16'h0000,   4'd8, 1'b1, 1'b0, 9};
        vecs[6]  = '{16'd2,      16'h0003, 16'd1,      4'd1, 1'b0, 1'b0, 2};
        vecs[7]  = '{16'd3,      16'h0003, 16'd0,      4'd8, 1'b1, 1'b0, 9};
        vecs[8]  = '{16'd5,      16'h0006, 16'd1,      4'd8, 1'b1, 1'b0, 9};
        vecs[9]  = '{16'd16,     16'h00AB, 16'd11,     4'd1, 1'b0, 1'b0, 2};
        vecs[10] = '{16'd17,     16'h001F, 16'd14,     4'd8, 1'b1, 1'b0, 9};
        vecs[11] = '{16'h8001,   16'h8000, 16'h8000,   4'd1, 1'b0, 1'b0, 2};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_tries", 32'(bus.rsp_tries), 32'd0);
        check("rst_rsp_biased", 32'(bus.rsp_biased), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        reset = 1'b1;
        #1;
        check("req_ready_pre_edge", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("req_ready_first_edge", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            lfsr = {32'($urandom), 16'($urandom), vecs[i].lfsr_lo};
            issue(vecs[i]);
            collect(0);
        end

        // Reject once, then accept on the second draw
        v = '{16'd200, 16'h0000, 16'd5, 4'd2, 1'b0, 1'b0, 3};
        lfsr = {48'hABCD_EF01_2345, 16'h00FF};
        issue(v);
        @(negedge clk);
        lfsr = {48'h1357_9BDF_0246, 16'h1205};
        collect(0);

        // Consumer stalls on an accepted and on a fallback response
        lfsr = {48'h0, 16'h00AB};
        issue('{16'd16, 16'h00AB, 16'd11, 4'd1, 1'b0, 1'b0, 2});
        collect(5);
        lfsr = {48'hFFFF_0000_FFFF, 16'h00FA};
        issue('{16'd200, 16'h00FA, 16'd50, 4'd8, 1'b1, 1'b0, 9});
        collect(5);

        // Reset pulsed mid-DRAW on a rejecting stream
        lfsr = {48'h0, 16'h00FA};
        issue('{16'd200, 16'h00FA, 16'd50, 4'd8, 1'b1, 1'b0, 9});
        v = exp_q.pop_back();
        repeat (2) @(negedge clk);
        rose = bus.rsp_valid;
        reset = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_rsp_tries", 32'(bus.rsp_tries), 32'd0);
        check("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
        repeat (3) begin
            @(negedge clk);
            rose = rose | bus.rsp_valid;
        end
        reset = 1'b1;
        @(negedge clk);
        check("postrst_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (12) begin
            @(negedge clk);
            rose = rose | bus.rsp_valid;
        end
        check("midrst_no_response", 32'(rose), 32'd0);

        lfsr = {48'h0, 16'h00AB};
        issue('{16'd16, 16'h00AB, 16'd11, 4'd1, 1'b0, 1'b0, 2});
        collect(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rand_range_sampler.md
RAND_RANGE_SAMPLER -- requirements
Module: rand_range_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of limit and result.
REQ-002 SHALL have parameter MAX_TRIES, default 8, legal range 1..15: maximum draws per request before fallback.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port lfsr_state, input, 64: free-running state output of the upstream 64-bit LFSR, which advances every clk.
REQ-006 SHALL have port req_valid, input, 1: request present.
REQ-007 SHALL have port req_ready, output, 1: block can accept a request.
REQ-008 SHALL have port req_limit, input, WIDTH: exclusive upper bound of the requested number.
REQ-009 SHALL have port rsp_valid, output, 1: response present.
REQ-010 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-011 SHALL have port rsp_data, output, WIDTH: result, always in [0, limit-1] when limit is at least 1.
REQ-012 SHALL have port rsp_tries, output, 4: number of draws consumed (1..MAX_TRIES); 0 for an error response.
REQ-013 SHALL have port rsp_biased, output, 1: result produced by fallback, not by uniform acceptance.
REQ-014 SHALL have port rsp_err, output, 1: request had limit = 0.

Function
REQ-015 SHALL implement an FSM with states IDLE, DRAW and RESP.
REQ-016 SHALL assert req_ready only in IDLE, driven from a registered state with no combinational path from any input.
REQ-017 SHALL, on request handshake (req_valid && req_ready at a clk edge):
- latch limit;
- latch mask = (smallest 2^k) - 1 that is >= limit-1 (limit=1 gives mask=0; limit=0x8000 gives mask=0x7FFF);
- clear the try counter.
REQ-018 SHALL, on handshake with limit = 0, go directly to RESP with rsp_data=0, rsp_err=1, rsp_tries=0, rsp_biased=0.
REQ-019 SHALL, at each edge in DRAW:
- form candidate = lfsr_state[WIDTH-1:0] & mask;
- increment tries;
- if candidate < limit, register rsp_data=candidate and rsp_biased=0, then go to RESP.
REQ-020 SHALL, in DRAW when the draw is rejected and tries reaches MAX_TRIES, register rsp_data = candidate - limit and rsp_biased=1, then go to RESP; this result is always < limit because candidate < 2*limit.
REQ-021 SHALL have a minimum latency of 2 edges: handshake at edge E0, first draw at E1, rsp_valid high after E1.
REQ-022 SHALL have a maximum latency of MAX_TRIES+1 edges.
REQ-023 SHALL, in RESP, hold rsp_valid=1 and keep rsp_data, rsp_tries, rsp_biased and rsp_err stable until rsp_ready=1 at an edge, then go to IDLE.
REQ-024 SHALL ignore req_valid and req_limit while not in IDLE; limit changes mid-request have no effect.
REQ-025 SHALL drive rsp_valid only from registered state; rsp_valid=0 in IDLE and DRAW.
REQ-026 SHALL perform all compares and subtracts unsigned at WIDTH bits, with no overflow possible.

Reset
REQ-027 SHALL, on reset low, immediately (asynchronously) force state=IDLE and clear the try counter.
REQ-028 SHALL, on reset low, immediately force rsp_valid=0, rsp_data=0, rsp_tries=0, rsp_biased=0 and rsp_err=0.
REQ-029 SHALL, on reset low, immediately force req_ready=0.
REQ-030 SHALL assert req_ready=1 at the first clk edge after reset deasserts.
REQ-031 SHALL, when reset is asserted mid-DRAW or mid-RESP, discard the request in flight with no response emitted.

Verification
REQ-032 SHALL be verified by: limit=1 with any lfsr_state -> rsp_valid at E1+, data=0, tries=1, biased=0.
REQ-033 SHALL be verified by: limit=0 -> RESP after E0 with data=0, err=1, tries=0.
REQ-034 SHALL be verified by: limit=200 (mask 0xFF) with lfsr_state low bits 0x00FF at E1 then 0x1205 at E2 -> data=5, tries=2, biased=0.
REQ-035 SHALL be verified by: limit=200 with lfsr_state low bits held at 0x00FA, MAX_TRIES=8 -> data=50, tries=8, biased=1, rsp_valid after E8.
REQ-036 SHALL be verified by: rsp_ready held low 5 cycles in RESP -> outputs stable and req_ready=0 throughout; IDLE one edge after rsp_ready=1.
REQ-037 SHALL be verified by: reset pulsed low mid-DRAW (limit=200, rejecting stream) -> rsp_valid never rises, and a new request after release completes normally.
